hazard_unit: RTL and testbench

Parametrised hazard controller for the five-stage RISC-V pipeline. It replaces the stall-free, forward-free flow of the current top with three mechanisms:
- operand forwarding into execute;
- load-use stalls and branch-taken flushes resolved in memory;
- a multi-cycle data-memory wait state machine with a configurable latency.

It also keeps wrap-around performance counters. The block sits beside the fetch/decode/execute/memory stages and drives their pipeline-register stall and flush controls.

---
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_perf.sv | 35 +++
 rtl/hazard_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard controller: operand-forward selects
// and the data-memory wait state machine.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int WAIT_W = 4;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_unit_perf.sv
// Wrap-around performance counters for the hazard controller: cycles, stall cycles, flush events.
// Counts update one edge after the qualifying event; there is no backpressure.
module hazard_perf #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stallEv,
    input  logic             i_flushEv,
    output logic [CNT_W-1:0] o_cycleCnt,
    output logic [CNT_W-1:0] o_stallCnt,
    output logic [CNT_W-1:0] o_flushCnt
);

    logic [CNT_W-1:0] r_cycleCnt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycleCnt <= '0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            r_cycleCnt <= r_cycleCnt + 1'b1;
            if (i_stallEv) r_stallCnt <= r_stallCnt + 1'b1;
            if (i_flushEv) r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    assign o_cycleCnt = r_cycleCnt;
    assign o_stallCnt = r_stallCnt;
    assign o_flushCnt = r_flushCnt;

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall, branch flush, memory wait FSM.
// Controls are combinational in the same cycle; a memory access holds the whole pipe for MEM_LAT cycles.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int WORD    = 32,
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [REG_W-1:0] i_rs1D,
    input  logic [REG_W-1:0] i_rs2D,
    input  logic [REG_W-1:0] i_rs1E,
    input  logic [REG_W-1:0] i_rs2E,
    input  logic [REG_W-1:0] i_writeRegE,
    input  logic [REG_W-1:0] i_writeRegM,
    input  logic [REG_W-1:0] i_writeRegW,
    input  logic             i_regWriteM,
    input  logic             i_regWriteW,
    input  logic             i_mem2regE,
    input  logic             i_memAccessM,
    input  logic             i_PCSrcM,
    output logic [1:0]       o_fwdAE,
    output logic [1:0]       o_fwdBE,
    output logic             o_stallF,
    output logic             o_stallD,
    output logic             o_stallE,
    output logic             o_stallM,
    output logic             o_flushD,
    output logic             o_flushE,
    output logic             o_flushM,
    output logic             o_flushW,
    output logic [CNT_W-1:0] o_cycleCnt,
    output logic [CNT_W-1:0] o_stallCnt,
    output logic [CNT_W-1:0] o_flushCnt
);

    localparam logic [WAIT_W-1:0] LAT_M1 = WAIT_W'((MEM_LAT == 0) ? 0 : MEM_LAT - 1);

    hz_state_t         r_state;
    hz_state_t         w_nextState;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [WAIT_W-1:0] w_nextWait;
    logic              w_memStall;
    logic              w_loadUse;
    logic              w_stallEv;
    logic              w_flushEv;

    // Memory-stage result wins over writeback: it is the younger producer.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
        if (rs == '0)                                  return FWD_RF;
        else if (i_regWriteM && (i_writeRegM == rs))   return FWD_M;
        else if (i_regWriteW && (i_writeRegW == rs))   return FWD_W;
        else                                           return FWD_RF;
    endfunction

    assign w_loadUse = i_mem2regE && (i_writeRegE != '0) &&
                       ((i_writeRegE == i_rs1D) || (i_writeRegE == i_rs2D));

    always_comb begin
        w_memStall  = 1'b0;
        w_nextState = r_state;
        w_nextWait  = r_waitCnt;
        case (r_state)
            HZ_IDLE: begin
                if (i_memAccessM && (MEM_LAT != 0)) begin
                    w_memStall  = 1'b1;
                    w_nextState = HZ_WAIT;
                    w_nextWait  = LAT_M1;
                end
            end
            HZ_WAIT: begin
                w_memStall = (r_waitCnt != '0);
                if (r_waitCnt == '0) w_nextState = HZ_IDLE;
                else                 w_nextWait  = r_waitCnt - 1'b1;
            end
            default: w_nextState = HZ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= HZ_IDLE;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWait;
        end
    end

    always_comb begin
        o_fwdAE  = FWD_RF;
        o_fwdBE  = FWD_RF;
        o_stallF = 1'b0;
        o_stallD = 1'b0;
        o_stallE = 1'b0;
        o_stallM = 1'b0;
        o_flushD = 1'b0;
        o_flushE = 1'b0;
        o_flushM = 1'b0;
        o_flushW = 1'b0;
        if (i_reset) begin
            o_flushD = 1'b1;
            o_flushE = 1'b1;
            o_flushM = 1'b1;
            o_flushW = 1'b1;
        end else begin
            o_fwdAE = fwd_sel(i_rs1E);
            o_fwdBE = fwd_sel(i_rs2E);
            // A pending branch waits out the memory stall; it redirects once memory releases.
            if (w_memStall) begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_stallE = 1'b1;
                o_stallM = 1'b1;
                o_flushW = 1'b1;
            end else if (i_PCSrcM) begin
                o_flushD = 1'b1;
                o_flushE = 1'b1;
                o_flushM = 1'b1;
            end else if (w_loadUse) begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_flushE = 1'b1;
            end
        end
    end

    assign w_stallEv = w_memStall || (w_loadUse && !i_PCSrcM);
    assign w_flushEv = !w_memStall && i_PCSrcM;

    hazard_perf #(
        .CNT_W(CNT_W)
    ) u_perf (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_stallEv  (w_stallEv),
        .i_flushEv  (w_flushEv),
        .o_cycleCnt (o_cycleCnt),
        .o_stallCnt (o_stallCnt),
        .o_flushCnt (o_flushCnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (MEM_LAT 0, 3, 2) share one stimulus stream.
module tb_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int N     = 3;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] rs1D, rs2D, rs1E, rs2E, writeRegE, writeRegM, writeRegW;
    logic             regWriteM, regWriteW, mem2regE, memAccessM, PCSrcM;

    logic [1:0]       fwdAE [N];
    logic [1:0]       fwdBE [N];
    logic             stallF [N], stallD [N], stallE [N], stallM [N];
    logic             flushD [N], flushE [N], flushM [N], flushW [N];
    logic [CNT_W-1:0] cycleCnt [N], stallCnt [N], flushCnt [N];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        hazard_unit #(
            .WORD    (32),
            .REG_W   (REG_W),
            .MEM_LAT ((g == 0) ? 0 : (g == 1) ? 3 : 2),
            .CNT_W   (CNT_W)
        ) u_dut (
            .i_clk        (clk),
            .i_reset      (reset),
            .i_rs1D       (rs1D),
            .i_rs2D       (rs2D),
            .i_rs1E       (rs1E),
            .i_rs2E       (rs2E),
            .i_writeRegE  (writeRegE),
            .i_writeRegM  (writeRegM),
            .i_writeRegW  (writeRegW),
            .i_regWriteM  (regWriteM),
            .i_regWriteW  (regWriteW),
            .i_mem2regE   (mem2regE),
            .i_memAccessM (memAccessM),
            .i_PCSrcM     (PCSrcM),
            .o_fwdAE      (fwdAE[g]),
            .o_fwdBE      (fwdBE[g]),
            .o_stallF     (stallF[g]),
            .o_stallD     (stallD[g]),
            .o_stallE     (stallE[g]),
            .o_stallM     (stallM[g]),
            .o_flushD     (flushD[g]),
            .o_flushE     (flushE[g]),
            .o_flushM     (flushM[g]),
            .o_flushW     (flushW[g]),
            .o_cycleCnt   (cycleCnt[g]),
            .o_stallCnt   (stallCnt[g]),
            .o_flushCnt   (flushCnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
    function automatic logic [7:0] ctl(input int g);
        return {stallF[g], stallD[g], stallE[g], stallM[g],
                flushD[g], flushE[g], flushM[g], flushW[g]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        writeRegE = '0; writeRegM = '0; writeRegW = '0;
        regWriteM = 1'b0; regWriteW = 1'b0; mem2regE = 1'b0;
        memAccessM = 1'b0; PCSrcM = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("reset_ctl", 32'(ctl(0)), 32'h0F);
        chk("reset_fwd", 32'({fwdAE[0], fwdBE[0]}), 32'h0);
        tick();
        chk("reset_cycle", 32'(cycleCnt[0]), 32'h0);
        chk("reset_stall", 32'(stallCnt[1]), 32'h0);

        // Idle pipe, then cycle counter wrap at 4 bits
        reset = 1'b0;
        #1;
        chk("idle_ctl", 32'(ctl(0)), 32'h00);
        tick();
        chk("cycle_first", 32'(cycleCnt[0]), 32'h1);
        for (int i = 0; i < 14; i++) tick();
        chk("cycle_15", 32'(cycleCnt[0]), 32'hF);
        tick();
        chk("cycle_wrap", 32'(cycleCnt[0]), 32'h0);

        // Forwarding
        rs1E = 5'd5; writeRegM = 5'd5; regWriteM = 1'b1; writeRegW = 5'd5; regWriteW = 1'b1;
        #1;
        chk("fwdA_mem_prio", 32'(fwdAE[0]), 32'h2);
        chk("fwdB_x0", 32'(fwdBE[0]), 32'h0);
        rs1E = 5'd0;
        #1;
        chk("fwdA_x0", 32'(fwdAE[0]), 32'h0);
        rs1E = 5'd5; regWriteM = 1'b0;
        #1;
        chk("fwdA_wb", 32'(fwdAE[0]), 32'h1);
        rs2E = 5'd9; writeRegW = 5'd9; regWriteM = 1'b1;
        #1;
        chk("fwdA_mem_only", 32'(fwdAE[0]), 32'h2);
        chk("fwdB_wb", 32'(fwdBE[0]), 32'h1);
        regWriteM = 1'b0; regWriteW = 1'b0;
        #1;
        chk("fwd_no_write", 32'({fwdAE[0], fwdBE[0]}), 32'h0);
        clear_inputs();

        // Load-use
        pulse_reset();
        mem2regE = 1'b1; writeRegE = 5'd7; rs1D = 5'd3; rs2D = 5'd7;
        #1;
        chk("lu_ctl", 32'(ctl(0)), 32'hC4);
        tick();
        mem2regE = 1'b0;
        #1;
        chk("lu_bubble_ctl", 32'(ctl(0)), 32'h00);
        chk("lu_stallcnt", 32'(stallCnt[0]), 32'h1);
        mem2regE = 1'b1; writeRegE = 5'd0; rs1D = 5'd0;
        #1;
        chk("lu_x0_ctl", 32'(ctl(0)), 32'h00);
        tick();
        chk("lu_x0_stallcnt", 32'(stallCnt[0]), 32'h1);

        // Branch beats load-use
        writeRegE = 5'd7; rs2D = 5'd7; PCSrcM = 1'b1;
        #1;
        chk("br_lu_ctl", 32'(ctl(0)), 32'h0E);
        tick();
        chk("br_lu_stallcnt", 32'(stallCnt[0]), 32'h1);
        chk("br_lu_flushcnt", 32'(flushCnt[0]), 32'h1);
        clear_inputs();

        // Memory wait, MEM_LAT=3
        pulse_reset();
        memAccessM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_stall_%0d", i), 32'(ctl(1)), 32'hF1);
            chk($sformatf("mw_lat0_%0d", i), 32'(ctl(0)), 32'h00);
            tick();
        end
        chk("mw_release_ctl", 32'(ctl(1)), 32'h00);
        tick();
        chk("mw_stallcnt", 32'(stallCnt[1]), 32'h3);
        chk("mw_idle_restart", 32'(ctl(1)), 32'hF1);

        // Reset while in WAIT abandons the access
        tick();
        reset = 1'b1; memAccessM = 1'b0;
        #1;
        chk("mw_rst_ctl", 32'(ctl(1)), 32'h0F);
        tick();
        reset = 1'b0;
        #1;
        chk("mw_rst_idle", 32'(ctl(1)), 32'h00);
        chk("mw_rst_cnt", 32'({stallCnt[1], cycleCnt[1]}), 32'h0);

        // Branch held through a MEM_LAT=2 stall
        memAccessM = 1'b1; PCSrcM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("bm_stall_%0d", i), 32'(ctl(2)), 32'hF1);
            tick();
        end
        chk("bm_flush_ctl", 32'(ctl(2)), 32'h0E);
        chk("bm_flushcnt_pre", 32'(flushCnt[2]), 32'h0);
        tick();
        memAccessM = 1'b0; PCSrcM = 1'b0;
        #1;
        chk("bm_flushcnt", 32'(flushCnt[2]), 32'h1);
        chk("bm_stallcnt", 32'(stallCnt[2]), 32'h2);
        chk("bm_after_ctl", 32'(ctl(2)), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
